// File: rtl/spi_master.sv
// SPI mode-0 master: start/done user handshake, one DATA_WIDTH word per transfer.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first bit order on both mosi and miso.
module spi_master #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  done,
    output logic                  busy,
    output logic                  cs,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER_HI,
        S_XFER_LO,
        S_HOLD
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DIV_W-1:0]      r_div, w_div_nxt;
    logic [BIT_W-1:0]      r_bits, w_bits_nxt;
    logic [DATA_WIDTH-1:0] r_tx, w_tx_nxt;
    logic [DATA_WIDTH-1:0] r_rx, w_rx_nxt;
    logic [DATA_WIDTH-1:0] r_rx_data, w_rx_data_nxt;
    logic                  r_cs, w_cs_nxt;
    logic                  r_sck, w_sck_nxt;
    logic                  r_mosi, w_mosi_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;

    logic                  w_phase_end;
    logic                  w_last_bit;
    logic                  w_first_bit;
    logic                  w_next_bit;
    logic [DATA_WIDTH-1:0] w_tx_shift;
    logic [DATA_WIDTH-1:0] w_rx_shift;

    assign w_phase_end = (r_div == DIV_W'(CLK_DIV));
    assign w_last_bit  = (r_bits == BIT_W'(DATA_WIDTH));

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign w_first_bit = tx_data[0];
    assign w_next_bit  = r_tx[1];
    assign w_tx_shift  = {1'b0, r_tx[DATA_WIDTH-1:1]};
    assign w_rx_shift  = {miso, r_rx[DATA_WIDTH-1:1]};
`else
    assign w_first_bit = tx_data[DATA_WIDTH-1];
    assign w_next_bit  = r_tx[DATA_WIDTH-2];
    assign w_tx_shift  = {r_tx[DATA_WIDTH-2:0], 1'b0};
    assign w_rx_shift  = {r_rx[DATA_WIDTH-2:0], miso};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_bits    <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_cs      <= 1'b1;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_div     <= w_div_nxt;
            r_bits    <= w_bits_nxt;
            r_tx      <= w_tx_nxt;
            r_rx      <= w_rx_nxt;
            r_rx_data <= w_rx_data_nxt;
            r_cs      <= w_cs_nxt;
            r_sck     <= w_sck_nxt;
            r_mosi    <= w_mosi_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_nxt = S_SETUP;
            S_SETUP:   if (w_phase_end) w_state_nxt = S_XFER_HI;
            S_XFER_HI: if (w_phase_end) w_state_nxt = S_XFER_LO;
            S_XFER_LO: if (w_phase_end) w_state_nxt = w_last_bit ? S_HOLD : S_XFER_HI;
            S_HOLD:    if (w_phase_end) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // SETUP counts from 0 so cs leads the first sck rise by CLK_DIV+1 cycles
    always_comb begin
        w_div_nxt     = r_div;
        w_bits_nxt    = r_bits;
        w_tx_nxt      = r_tx;
        w_rx_nxt      = r_rx;
        w_rx_data_nxt = r_rx_data;
        w_cs_nxt      = r_cs;
        w_sck_nxt     = r_sck;
        w_mosi_nxt    = r_mosi;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_tx_nxt   = tx_data;
                    w_mosi_nxt = w_first_bit;
                    w_cs_nxt   = 1'b0;
                    w_busy_nxt = 1'b1;
                    w_div_nxt  = '0;
                    w_bits_nxt = '0;
                end
            end
            S_SETUP: begin
                w_div_nxt = r_div + DIV_W'(1);
                if (w_phase_end) begin
                    w_div_nxt  = DIV_W'(1);
                    w_sck_nxt  = 1'b1;
                    w_rx_nxt   = w_rx_shift;
                    w_bits_nxt = r_bits + BIT_W'(1);
                end
            end
            S_XFER_HI: begin
                w_div_nxt = r_div + DIV_W'(1);
                if (w_phase_end) begin
                    w_div_nxt = DIV_W'(1);
                    w_sck_nxt = 1'b0;
                    if (!w_last_bit) begin
                        w_tx_nxt   = w_tx_shift;
                        w_mosi_nxt = w_next_bit;
                    end
                end
            end
            S_XFER_LO: begin
                w_div_nxt = r_div + DIV_W'(1);
                if (w_phase_end) begin
                    w_div_nxt = DIV_W'(1);
                    if (!w_last_bit) begin
                        w_sck_nxt  = 1'b1;
                        w_rx_nxt   = w_rx_shift;
                        w_bits_nxt = r_bits + BIT_W'(1);
                    end
                end
            end
            S_HOLD: begin
                w_div_nxt = r_div + DIV_W'(1);
                if (w_phase_end) begin
                    w_div_nxt     = '0;
                    w_cs_nxt      = 1'b1;
                    w_busy_nxt    = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_rx_data_nxt = r_rx;
                    w_mosi_nxt    = 1'b0;
                end
            end
            default: begin
                w_div_nxt = '0;
            end
        endcase
    end

    assign rx_data = r_rx_data;
    assign done    = r_done;
    assign busy    = r_busy;
    assign cs      = r_cs;
    assign sck     = r_sck;
    assign mosi    = r_mosi;

endmodule
